// File: rtl/dna_pkg.sv
// rtl/dna_pkg.sv - shared digit type, complement map and sequencer states
package dna_pkg;

    typedef logic [1:0] digit_t;

    localparam digit_t D_0 = 2'b00;
    localparam digit_t D_1 = 2'b01;
    localparam digit_t D_2 = 2'b10;
    localparam digit_t D_3 = 2'b11;

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    function automatic digit_t comp_digit(input digit_t d);
        case (d)
            D_0:     return D_1;
            D_1:     return D_0;
            D_2:     return D_3;
            default: return D_2;
        endcase
    endfunction

endpackage

// File: rtl/revcomp_buf.sv
// rtl/revcomp_buf.sv - word buffer with one write port and a combinational read port
module revcomp_buf
    import dna_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_data
);

    // Contents are never reset: every entry is written before it is read.
    digit_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/revcomp_stream.sv
// rtl/revcomp_stream.sv - collects a word of digits, then emits it reversed and complemented
module revcomp_stream
    import dna_pkg::*;
#(
    parameter int WORD_DIGITS = 4,
    parameter int CNT_W       = $clog2(WORD_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_digit,
    output logic             out_last,
    output logic             out_eos,
    output logic [CNT_W-1:0] word_len,
    output logic             busy
);

    localparam int               IDX_W    = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] rd_idx;
    logic             eos_flag;
    logic             accept;
    logic             word_done;
    logic             out_fire;
    digit_t           rd_data;

    assign accept    = in_valid && in_ready;
    assign word_done = (fill_cnt == LAST_IDX) || in_last;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FILL: begin
                in_ready = !rst;
                if (in_valid && word_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (rd_idx == '0)) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Closing a word hands the fill position over as the drain start, so draining walks back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
            rd_idx   <= '0;
            eos_flag <= 1'b0;
            word_len <= '0;
        end else begin
            if (accept) begin
                if (word_done) begin
                    word_len <= fill_cnt + CNT_W'(1);
                    rd_idx   <= fill_cnt;
                    eos_flag <= in_last;
                    fill_cnt <= '0;
                end else begin
                    fill_cnt <= fill_cnt + CNT_W'(1);
                end
            end
            if (out_fire) begin
                if (rd_idx == '0) begin
                    eos_flag <= 1'b0;
                end else begin
                    rd_idx <= rd_idx - CNT_W'(1);
                end
            end
        end
    end

    revcomp_buf #(
        .DEPTH (WORD_DIGITS),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_idx  (fill_cnt[IDX_W-1:0]),
        .wr_data (in_digit),
        .rd_idx  (rd_idx[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    assign out_digit = comp_digit(rd_data);
    assign out_last  = out_valid && (rd_idx == '0);
    assign out_eos   = out_last && eos_flag;
    assign busy      = (state == DRAIN) || (fill_cnt != '0);

endmodule

// File: doc/revcomp_stream.md
Name: revcomp_stream

Overview:
- Streaming reverse-complement sequencer for 2-bit DNA digits.
- Collects up to WORD_DIGITS digits serially into an internal word buffer, then emits them in reverse order, each passed through the digit-complement map.
- Sits between the serial digit source (reader/decoder) and downstream strand consumers. Provides valid/ready handshakes on both sides.

Parameters:
- WORD_DIGITS, 4, digits per word (buffer depth); legal range 2..64.
- CNT_W, $clog2(WORD_DIGITS+1), width of fill/drain counters and word_len (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  source presents a digit.
- in_ready  out  1  block accepts a digit this cycle.
- in_digit  in  2  digit code (00=4/0, 01=1, 10=2, 11=3).
- in_last  in  1  digit is the final digit of the strand; closes a partial word.
- out_valid  out  1  complemented digit available.
- out_ready  in  1  sink accepts the digit.
- out_digit  out  2  complemented digit, in reverse order of arrival.
- out_last  out  1  final digit of the current word.
- out_eos  out  1  final digit of the strand (qualified with out_last).
- word_len  out  CNT_W  number of digits in the word being drained.
- busy  out  1  high in DRAIN, or in FILL with fill count > 0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset (async assert, sync release):
  - state=FILL, fill_cnt=0, rd_idx=0, eos_flag=0, word_len=0.
  - out_valid=0, out_last=0, out_eos=0, busy=0.
  - in_ready forced 0 while rst is high.
  - Buffer contents don't care.
- Complement map (fixed): 00->01, 01->00, 10->11, 11->10.
- State FILL:
  - in_ready=1.
  - On in_valid&in_ready: buf[fill_cnt]<=in_digit; fill_cnt++.
  - Go to DRAIN when fill_cnt==WORD_DIGITS-1 (word full) or in_last=1. On that transition:
    - word_len<=fill_cnt+1.
    - rd_idx<=fill_cnt.
    - eos_flag<=in_last.
    - fill_cnt<=0.
- State DRAIN:
  - in_ready=0.
  - out_valid=1.
  - out_digit=comp(buf[rd_idx]).
  - out_last=(rd_idx==0).
  - out_eos=(rd_idx==0)&eos_flag.
  - On out_valid&out_ready: if rd_idx==0, go to FILL and clear eos_flag; else rd_idx--.
- Outputs in DRAIN are driven from registered state only, with no combinational path from in_* to out_*. out_valid, out_digit and out_last are held stable while out_ready=0.
- Latency: the final accepted digit at edge t makes out_valid high after edge t. A word of L digits drains in L handshakes minimum.
- No overlap: the next word's first digit is accepted no earlier than the cycle after the last out handshake. Peak throughput is L/(2L) digits/cycle.
- in_last on the first digit gives L=1: a single output beat with out_last=out_eos=1.
- in_last coinciding with word-full: a single transition with eos_flag=1.
- in_valid while in DRAIN is ignored (in_ready=0); the source must hold.
- Reset mid-FILL or mid-DRAIN:
  - Immediate return to reset values.
  - The partial word is discarded and no further out beats are produced.
- fill_cnt never exceeds WORD_DIGITS-1. word_len is held from the DRAIN entry until the next DRAIN entry.

Decomposition:
- Package dna_pkg:
  - typedef logic [1:0] digit_t.
  - Digit constants D_0=2'b00, D_1=2'b01, D_2=2'b10, D_3=2'b11.
  - Function comp_digit(digit_t) implementing the complement map.
  - Enum state_t {FILL, DRAIN}.
- One sub-module: revcomp_buf. It holds the register array, write port (index, data, enable) and combinational read port (index). It is instantiated once.
- FSM and counters stay in the top level.

Test Plan:
- N=4. Send 0,1,2,3 with in_last on digit 3 -> out 10,11,00,01 (2,3,0,1). out_last=out_eos=1 on the 4th beat. word_len=4.
- N=4. Send 8 digits 3,3,0,2,1,1,2,0, in_last only on the 8th, out_ready=1 -> word A out 11,01,10,10 with out_last and out_eos=0. Word B out 01,11,00,00 with out_eos=1. in_ready is low during each drain.
- N=4. Single digit 2 with in_last -> one beat, out_digit=11, out_last=out_eos=1, word_len=1, then in_ready=1 the following cycle.
- Backpressure: word 0,1,2 with in_last, out_ready=0 for 5 cycles after out_valid rises -> out_digit stays 11 and out_valid stays 1. Release gives 11,00,01.
- Reset mid-drain: after first out beat of word 1,2,3,0 (in_last), pulse rst asynchronously -> out_valid=0 and in_ready=0 immediately. After release, in_ready=1, busy=0, and no stale digits appear.
- Random streams with random in_valid/out_ready against a scoreboard model of per-word reverse-complement -> zero mismatches over 10k digits.
